// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 32-bit result words in a small FIFO and sends each
// one on an 8N1 UART line as four bytes, byte 0 first, each byte LSB first.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          I_valid,
  input  logic [DATA_W-1:0]             I_result,
  output logic                          O_ready,
  output logic                          O_tx,
  output logic                          O_busy,
  output logic [$clog2(FIFO_DEPTH):0]   O_count,
  output logic                          O_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_state_nx;
  logic [BW-1:0]     r_baud, w_baud_nx;
  logic [2:0]        r_bit, w_bit_nx;
  logic [1:0]        r_byte, w_byte_nx;
  logic [DATA_W-1:0] r_shreg, w_shreg_nx;
  logic              r_tx, w_tx_nx;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_count, w_count_nx;
  logic              r_ready, r_busy, r_overflow;

  logic              w_push, w_pop, w_wrap, w_not_empty;
  logic [4:0]        w_idx;

  assign w_push      = I_valid & r_ready;
  assign w_not_empty = (r_count != '0);
  assign w_wrap      = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_idx       = {r_byte, r_bit};
  assign w_count_nx  = r_count + CW'(w_push) - CW'(w_pop);

  assign O_ready    = r_ready;
  assign O_tx       = r_tx;
  assign O_busy     = r_busy;
  assign O_count    = r_count;
  assign O_overflow = r_overflow;

  // FIFO storage; stale contents are unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= I_result;
  end

  // FIFO pointers, occupancy, status flags and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_nx;
      r_ready <= (w_count_nx != CW'(FIFO_DEPTH));
      r_busy  <= (w_state_nx != IDLE) | (w_count_nx != '0);
      if (I_valid && !r_ready) r_overflow <= 1'b1;
    end
  end

  // Serialiser state, counters and line register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_byte  <= w_byte_nx;
      r_shreg <= w_shreg_nx;
      r_tx    <= w_tx_nx;
    end
  end

  // Next state, pop strobe and next line level; bits advance only on baud wrap
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_byte_nx  = r_byte;
    w_shreg_nx = r_shreg;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    if (r_state != IDLE) w_baud_nx = w_wrap ? '0 : r_baud + BW'(1);
    unique case (r_state)
      IDLE: begin
        w_tx_nx   = 1'b1;
        w_baud_nx = '0;
        if (w_not_empty) begin
          w_pop      = 1'b1;
          w_shreg_nx = r_mem[r_rd];
          w_byte_nx  = '0;
          w_state_nx = START;
          w_tx_nx    = 1'b0;
        end
      end
      START: begin
        if (w_wrap) begin
          w_bit_nx   = '0;
          w_state_nx = DATA;
          w_tx_nx    = r_shreg[{r_byte, 3'd0}];
        end
      end
      DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx = r_bit + 3'd1;
            w_tx_nx  = r_shreg[5'(w_idx + 5'd1)];
          end
        end
      end
      STOP: begin
        if (w_wrap) begin
          if (r_byte != 2'd3) begin
            w_byte_nx  = r_byte + 2'd1;
            w_state_nx = START;
            w_tx_nx    = 1'b0;
          end else if (w_not_empty) begin
            // back-to-back word: next start bit follows this stop bit directly
            w_pop      = 1'b1;
            w_shreg_nx = r_mem[r_rd];
            w_byte_nx  = '0;
            w_state_nx = START;
            w_tx_nx    = 1'b0;
          end else begin
            w_state_nx = IDLE;
            w_tx_nx    = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: queue/timer reference model checked every cycle,
// a table of burst-push vectors, directed corner sequences and random traffic.
module tb_result_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam int WORD_CYC = 40 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        I_valid;
  logic [31:0] I_result;
  logic        O_ready, O_tx, O_busy, O_overflow;
  logic [2:0]  O_count;

  result_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .I_valid(I_valid), .I_result(I_result),
    .O_ready(O_ready), .O_tx(O_tx), .O_busy(O_busy), .O_count(O_count),
    .O_overflow(O_overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: words waiting in the FIFO plus remaining line time of
  // the word currently being sent.
  logic [31:0] mq[$];
  logic [31:0] m_cur;
  int          m_rem = 0;
  bit          m_ovf = 0;

  always @(posedge clk) begin
    int pre;
    if (reset) begin
      mq.delete();
      m_rem = 0;
      m_ovf = 0;
    end else begin
      pre = mq.size();
      if (m_rem > 0) m_rem--;
      if (m_rem == 0 && pre > 0) begin
        m_cur = mq.pop_front();
        m_rem = WORD_CYC;
      end
      if (I_valid) begin
        if (pre == D) m_ovf = 1;
        else mq.push_back(I_result);
      end
    end
  end

  function automatic int exp_tx();
    int k, pos, b, by;
    if (m_rem == 0) return 1;
    k   = WORD_CYC - m_rem;
    pos = k / C;
    b   = pos % 10;
    by  = pos / 10;
    if (b == 0) return 0;
    if (b == 9) return 1;
    return int'(m_cur[by*8 + b - 1]);
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx",       int'(O_tx),       exp_tx());
      check("count",    int'(O_count),    mq.size());
      check("ready",    int'(O_ready),    int'(mq.size() != D));
      check("busy",     int'(O_busy),     int'(m_rem > 0 || mq.size() > 0));
      check("overflow", int'(O_overflow), int'(m_ovf));
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    I_valid  = v;
    I_result = d;
    reset    = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && O_busy; i++) step(1'b0, 32'h0, 1'b0);
    check("drain_timeout", int'(i < max_cyc), 1);
  endtask

  typedef struct {
    int n_push;
    int exp_count;
    int exp_ready;
    int exp_ovf;
  } vec_t;

  vec_t vecs[6];
  int   cyc, lows;

  initial begin
    vecs[0] = '{1, 1, 1, 0};
    vecs[1] = '{2, 1, 1, 0};
    vecs[2] = '{3, 2, 1, 0};
    vecs[3] = '{4, 3, 1, 0};
    vecs[4] = '{5, 4, 0, 0};
    vecs[5] = '{6, 4, 0, 1};

    I_valid = 0; I_result = 0; reset = 1;
    @(negedge clk);
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    check("rst_tx",    int'(O_tx), 1);
    check("rst_ready", int'(O_ready), 1);
    check("rst_count", int'(O_count), 0);
    check("rst_busy",  int'(O_busy), 0);
    check("rst_ovf",   int'(O_overflow), 0);
    step(1'b0, 32'h0, 1'b0);
    chk_en = 1;

    // Single word: start bit one edge after push, busy for 1+160 edges
    step(1'b1, 32'hA5C3_0F01, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("single_start", int'(O_tx), 0);
    for (cyc = 1; cyc < 400 && O_busy; cyc++) step(1'b0, 32'h0, 1'b0);
    check("single_busy_len", cyc, 1 + WORD_CYC);

    // Burst pushes from idle
    foreach (vecs[r]) begin
      do_reset(2);
      for (int i = 0; i < vecs[r].n_push; i++) step(1'b1, $urandom, 1'b0);
      check("burst_count", int'(O_count),    vecs[r].exp_count);
      check("burst_ready", int'(O_ready),    vecs[r].exp_ready);
      check("burst_ovf",   int'(O_overflow), vecs[r].exp_ovf);
      step(1'b0, 32'h0, 1'b0);
      drain(6 * WORD_CYC);
      check("burst_ovf_sticky", int'(O_overflow), vecs[r].exp_ovf);
    end

    // Two words back to back: 80 bit times with no idle gap
    do_reset(2);
    step(1'b1, 32'h1234_5678, 1'b0);
    step(1'b1, 32'h9ABC_DEF0, 1'b0);
    for (cyc = 0; cyc < 800 && O_busy; cyc++) step(1'b0, 32'h0, 1'b0);
    check("two_word_len", cyc, 2 * WORD_CYC);

    // Reset during byte 2 data bits with two words queued
    do_reset(2);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 1'b0);
    step(1'b1, 32'h0BAD_C0DE, 1'b0);
    check("pre_abort_count", int'(O_count), 2);
    for (int i = 0; i < 90; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("abort_tx",    int'(O_tx), 1);
    check("abort_count", int'(O_count), 0);
    check("abort_ovf",   int'(O_overflow), 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (!O_tx) lows++;
    end
    check("abort_no_resend", lows, 0);

    // Push on the same edge as a back-to-back pop with two words queued
    do_reset(2);
    step(1'b1, 32'h1111_1111, 1'b0);
    step(1'b1, 32'h2222_2222, 1'b0);
    step(1'b1, 32'h3333_3333, 1'b0);
    for (cyc = 0; cyc < 400 && m_rem != 1; cyc++) step(1'b0, 32'h0, 1'b0);
    check("pop_wait_timeout", int'(cyc < 400), 1);
    step(1'b1, 32'h4444_4444, 1'b0);
    check("pushpop_count", int'(O_count), 2);
    drain(5 * WORD_CYC);

    // Randomised traffic at several push densities, occasional reset
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      pct = (seg == 0) ? 1 : (seg == 1) ? 3 : (seg == 2) ? 40 : 0;
      for (int i = 0; i < 1500; i++)
        step($urandom_range(0, 99) < pct, $urandom, $urandom_range(0, 1999) == 0);
    end
    drain(6 * WORD_CYC);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
